// File: rtl/jtag_vdr_bank.sv
// JTAG virtual data-register bank: one shared shift register feeding ident,
// memory read/write address/data targets and generic capture/update channels.
module jtag_vdr_bank #(
    parameter int unsigned          DR_LENGTH     = 32,
    parameter int unsigned          NUM_CH        = 4,
    parameter logic [31:0]          IDENT         = 32'h5A17C0DE,
    parameter logic [DR_LENGTH-1:0] CH_INIT       = '0,
    parameter int unsigned          ADDR_STEP     = 1,
    parameter int unsigned          FAST_WRITE    = 1,
    parameter int unsigned          WR_STROBE_DLY = 5,
    parameter int unsigned          WR_INC_DLY    = 7,
    parameter int unsigned          RD_INC_DLY    = 7
) (
    input  logic                          tck,
    input  logic                          reset,
    input  logic                          tdi,
    output logic                          vdr_tdo,
    input  logic                          capture_dr,
    input  logic                          shift_dr,
    input  logic                          update_dr,
    input  logic                          ident_enable,
    input  logic                          raddr_enable,
    input  logic                          waddr_enable,
    input  logic                          rdata_enable,
    input  logic                          wdata_enable,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic [NUM_CH*DR_LENGTH-1:0]   ch_in,
    output logic [NUM_CH*DR_LENGTH-1:0]   ch_out,
    input  logic [DR_LENGTH-1:0]          rdata_in,
    output logic [DR_LENGTH-1:0]          raddr_out,
    output logic [DR_LENGTH-1:0]          waddr_out,
    output logic [DR_LENGTH-1:0]          wdata_out,
    output logic                          wram_enable,
    output logic                          wr_overrun
);

    localparam int unsigned          CNT_W     = $clog2(DR_LENGTH);
    localparam logic [DR_LENGTH-1:0] IDENT_VAL = DR_LENGTH'(IDENT);
    localparam logic [DR_LENGTH-1:0] STEP      = DR_LENGTH'(ADDR_STEP);

    logic [DR_LENGTH-1:0]  vdr;
    logic [DR_LENGTH-1:0]  cap_val;
    logic                  cap_hit;
    logic [DR_LENGTH-1:0]  ch_q [NUM_CH];
    logic [RD_INC_DLY-1:0] rd_pipe;
    logic [WR_INC_DLY-1:0] wr_pipe;
    logic                  rd_inc;
    logic                  wr_inc;
    logic                  rd_launch;
    logic                  latch;

    assign vdr_tdo   = vdr[0];
    assign rd_launch = capture_dr & rdata_enable;

    // Capture source select: ident, then rdata, then lowest enabled channel.
    always_comb begin
        cap_hit = 1'b1;
        cap_val = '0;
        if (ident_enable) begin
            cap_val = IDENT_VAL;
        end else if (rdata_enable) begin
            cap_val = rdata_in;
        end else begin
            cap_hit = 1'b0;
            for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
                if (ch_enable[k]) begin
                    cap_hit = 1'b1;
                    cap_val = ch_in[k*DR_LENGTH +: DR_LENGTH];
                end
            end
        end
    end

    // Write latch source: shift-count wrap (fast) or update_dr (slow).
    if (FAST_WRITE != 0) begin : g_fast
        logic [CNT_W-1:0] shift_cnt;
        logic             latch_pulse;

        always_ff @(posedge tck) begin
            if (reset) begin
                shift_cnt   <= '0;
                latch_pulse <= 1'b0;
            end else begin
                latch_pulse <= 1'b0;
                if (!wdata_enable || capture_dr) begin
                    shift_cnt <= '0;
                end else if (shift_dr) begin
                    if (shift_cnt == CNT_W'(DR_LENGTH - 1)) begin
                        shift_cnt   <= '0;
                        latch_pulse <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end
            end
        end

        assign latch = latch_pulse;
    end else begin : g_slow
        assign latch = update_dr & wdata_enable;
    end

    // Per-channel update registers.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        always_ff @(posedge tck) begin
            if (reset) begin
                ch_q[k] <= CH_INIT;
            end else if (update_dr && ch_enable[k]) begin
                ch_q[k] <= vdr;
            end
        end

        assign ch_out[k*DR_LENGTH +: DR_LENGTH] = ch_q[k];
    end

    // Shift register, address/data registers and token delay lines.
    always_ff @(posedge tck) begin
        if (reset) begin
            vdr         <= '0;
            raddr_out   <= '0;
            waddr_out   <= '0;
            wdata_out   <= '0;
            rd_inc      <= 1'b0;
            wr_inc      <= 1'b0;
            rd_pipe     <= '0;
            wr_pipe     <= '0;
            wram_enable <= 1'b0;
            wr_overrun  <= 1'b0;
        end else begin
            if (capture_dr && cap_hit) begin
                vdr <= cap_val;
            end else if (shift_dr) begin
                vdr <= {tdi, vdr[DR_LENGTH-1:1]};
            end

            rd_pipe     <= (rd_pipe << 1) | RD_INC_DLY'(rd_launch);
            wr_pipe     <= (wr_pipe << 1) | WR_INC_DLY'(latch);
            wram_enable <= wr_pipe[WR_STROBE_DLY-1];

            if (update_dr && raddr_enable) begin
                raddr_out <= vdr;
                rd_inc    <= 1'b0;
            end else if (rd_pipe[RD_INC_DLY-1] && rd_inc) begin
                raddr_out <= raddr_out + STEP;
            end
            if (rd_launch) begin
                rd_inc <= 1'b1;
            end

            // An address load discards an increment landing on the same edge.
            if (update_dr && waddr_enable) begin
                waddr_out  <= vdr;
                wr_inc     <= 1'b0;
                wr_overrun <= 1'b0;
            end else if (wr_pipe[WR_INC_DLY-1] && wr_inc) begin
                waddr_out <= waddr_out + STEP;
            end
            if (latch) begin
                wdata_out <= vdr;
                wr_inc    <= 1'b1;
                if (|wr_pipe) begin
                    wr_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_vdr_bank.sv
// Directed bench for jtag_vdr_bank: a 32-bit fast-write instance plus an
// 8-bit update-latched instance for the overrun and truncation cases.
module tb_jtag_vdr_bank;

    typedef struct {
        bit           cap;
        logic [4:0]   en;
        logic [3:0]   ch_en;
        logic [31:0]  data;
        logic [31:0]  exp_word;
        logic [127:0] exp_ch;
        logic [31:0]  exp_raddr;
        logic [31:0]  exp_waddr;
    } vec_t;

    localparam logic [4:0] EN_NONE  = 5'b00000;
    localparam logic [4:0] EN_IDENT = 5'b10000;
    localparam logic [4:0] EN_RADDR = 5'b01000;
    localparam logic [4:0] EN_WADDR = 5'b00100;
    localparam logic [4:0] EN_RDATA = 5'b00010;
    localparam logic [4:0] EN_WDATA = 5'b00001;
    localparam int NV = 11;

    logic tck = 1'b0;
    logic reset, tdi, capture_dr, shift_dr, update_dr;
    logic ident_en, raddr_en, waddr_en, rdata_en, wdata_en;
    logic [3:0] ch_en;

    logic [127:0] ch_in32;
    logic [31:0]  rdata32;
    logic         tdo32, wram32, ovr32;
    logic [127:0] ch_out32;
    logic [31:0]  raddr32, waddr32, wdata32;

    logic [15:0]  ch_in8;
    logic [7:0]   rdata8;
    logic         tdo8, wram8, ovr8;
    logic [15:0]  ch_out8;
    logic [7:0]   raddr8, waddr8, wdata8;

    int errors = 0;
    int checks = 0;

    always #5 tck = ~tck;

    jtag_vdr_bank u_dut (
        .tck(tck), .reset(reset), .tdi(tdi), .vdr_tdo(tdo32),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .ident_enable(ident_en), .raddr_enable(raddr_en), .waddr_enable(waddr_en),
        .rdata_enable(rdata_en), .wdata_enable(wdata_en),
        .ch_enable(ch_en), .ch_in(ch_in32), .ch_out(ch_out32),
        .rdata_in(rdata32), .raddr_out(raddr32), .waddr_out(waddr32),
        .wdata_out(wdata32), .wram_enable(wram32), .wr_overrun(ovr32)
    );

    jtag_vdr_bank #(
        .DR_LENGTH(8), .NUM_CH(2), .CH_INIT(8'hA5), .FAST_WRITE(0)
    ) u_dut8 (
        .tck(tck), .reset(reset), .tdi(tdi), .vdr_tdo(tdo8),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .ident_enable(ident_en), .raddr_enable(raddr_en), .waddr_enable(waddr_en),
        .rdata_enable(rdata_en), .wdata_enable(wdata_en),
        .ch_enable(ch_en[1:0]), .ch_in(ch_in8), .ch_out(ch_out8),
        .rdata_in(rdata8), .raddr_out(raddr8), .waddr_out(waddr8),
        .wdata_out(wdata8), .wram_enable(wram8), .wr_overrun(ovr8)
    );

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_en(input logic [4:0] en, input logic [3:0] ch);
        {ident_en, raddr_en, waddr_en, rdata_en, wdata_en} = en;
        ch_en = ch;
    endtask

    task automatic shift_bits(input logic [31:0] w, input int n,
                              output logic [31:0] got32, output logic [7:0] got8);
        got32 = '0;
        got8  = '0;
        for (int i = 0; i < n; i++) begin
            tdi      = w[5'(i)];
            shift_dr = 1'b1;
            got32[5'(i)] = tdo32;
            if (i < 8) got8[3'(i)] = tdo8;
            tick();
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
    endtask

    task automatic pulse_update(input logic [4:0] en, input logic [3:0] ch);
        set_en(en, ch);
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        set_en(EN_NONE, 4'b0000);
    endtask

    task automatic pulse_capture(input logic [4:0] en, input logic [3:0] ch);
        set_en(en, ch);
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        set_en(EN_NONE, 4'b0000);
    endtask

    vec_t vecs[NV];
    logic [31:0] g32;
    logic [7:0]  g8;
    logic [31:0] words[3];
    logic [127:0] ch_a, ch_b;

    initial begin
        ch_a = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
        ch_b = {32'h0, 32'hDEADBEEF, 32'h0, 32'h12345678};
        vecs[0]  = '{1'b0, EN_NONE,  4'b0100, 32'hDEADBEEF, 32'h0, ch_a, 32'h0,   32'h0};
        vecs[1]  = '{1'b0, EN_NONE,  4'b0001, 32'h12345678, 32'h0, ch_b, 32'h0,   32'h0};
        vecs[2]  = '{1'b0, EN_RADDR, 4'b0000, 32'h00000100, 32'h0, ch_b, 32'h100, 32'h0};
        vecs[3]  = '{1'b0, EN_WADDR, 4'b0000, 32'h00000040, 32'h0, ch_b, 32'h100, 32'h40};
        vecs[4]  = '{1'b0, EN_NONE,  4'b0000, 32'hFFFFFFFF, 32'h0, ch_b, 32'h100, 32'h40};
        vecs[5]  = '{1'b1, EN_NONE,  4'b0100, 32'h0, 32'hC2C20002, '0, 32'h0, 32'h0};
        vecs[6]  = '{1'b1, EN_IDENT, 4'b0000, 32'h0, 32'h5A17C0DE, '0, 32'h0, 32'h0};
        vecs[7]  = '{1'b1, EN_IDENT, 4'b0001, 32'h0, 32'h5A17C0DE, '0, 32'h0, 32'h0};
        vecs[8]  = '{1'b1, EN_NONE,  4'b0110, 32'h0, 32'hC1C10001, '0, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, EN_NONE,  4'b1000, 32'hA5A55A5A, 32'hC3C30003, '0, 32'h0, 32'h0};
        vecs[10] = '{1'b1, EN_NONE,  4'b0000, 32'h0, 32'hA5A55A5A, '0, 32'h0, 32'h0};

        ch_in32 = {32'hC3C30003, 32'hC2C20002, 32'hC1C10001, 32'hC0C00000};
        ch_in8  = 16'h9291;
        rdata32 = 32'h0;
        rdata8  = 8'h0;
        tdi = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        set_en(EN_NONE, 4'b0000);
        reset = 1'b1;
        tick();
        tick();

        check("rst_tdo",   128'(tdo32),    128'(0));
        check("rst_raddr", 128'(raddr32),  128'(0));
        check("rst_waddr", 128'(waddr32),  128'(0));
        check("rst_wdata", 128'(wdata32),  128'(0));
        check("rst_wram",  128'(wram32),   128'(0));
        check("rst_ovr",   128'(ovr32),    128'(0));
        check("rst_ch",    ch_out32,       128'(0));
        reset = 1'b0;

        // Scan-in updates and capture/scan-out vectors.
        for (int i = 0; i < NV; i++) begin
            if (!vecs[i].cap) begin
                shift_bits(vecs[i].data, 32, g32, g8);
                pulse_update(vecs[i].en, vecs[i].ch_en);
                check($sformatf("vec%0d_ch", i),    ch_out32,         vecs[i].exp_ch);
                check($sformatf("vec%0d_raddr", i), 128'(raddr32),    128'(vecs[i].exp_raddr));
                check($sformatf("vec%0d_waddr", i), 128'(waddr32),    128'(vecs[i].exp_waddr));
            end else begin
                pulse_capture(vecs[i].en, vecs[i].ch_en);
                shift_bits(vecs[i].data, 32, g32, g8);
                check($sformatf("vec%0d_word", i),  128'(g32),        128'(vecs[i].exp_word));
            end
        end

        // Read-address auto-increment, 7 cycles after each rdata capture.
        for (int j = 0; j < 3; j++) begin
            pulse_capture(EN_RDATA, 4'b0000);
            for (int n = 1; n <= 9; n++) begin
                tick();
                if (n == 6) check($sformatf("rinc%0d_pre", j),  128'(raddr32), 128'(32'h100 + j));
                if (n == 7) check($sformatf("rinc%0d_post", j), 128'(raddr32), 128'(32'h101 + j));
            end
        end

        // Address update on the increment edge wins.
        rdata32 = 32'h200;
        pulse_capture(EN_RDATA, 4'b0000);
        for (int n = 1; n <= 6; n++) tick();
        check("rcoll_pre", 128'(raddr32), 128'(32'h103));
        pulse_update(EN_RADDR, 4'b0000);
        check("rcoll_upd", 128'(raddr32), 128'(32'h200));
        for (int n = 0; n < 10; n++) tick();
        check("rcoll_hold", 128'(raddr32), 128'(32'h200));

        // Fast write: 96 continuous shifts give three latches.
        shift_bits(32'h40, 32, g32, g8);
        pulse_update(EN_WADDR, 4'b0000);
        words[0] = 32'hA1B2C3D4;
        words[1] = 32'h0BADF00D;
        words[2] = 32'hCAFEBABE;
        wdata_en = 1'b1;
        for (int c = 1; c <= 108; c++) begin
            if (c <= 96) begin
                g32      = words[(c - 1) / 32];
                tdi      = g32[5'((c - 1) % 32)];
                shift_dr = 1'b1;
            end else begin
                tdi      = 1'b0;
                shift_dr = 1'b0;
            end
            tick();
            check($sformatf("fw_wram_c%0d", c), 128'(wram32),
                  128'(c == 38 || c == 70 || c == 102));
            if (c == 32) check("fw_wdata_c32", 128'(wdata32), 128'(0));
            if (c == 33) check("fw_wdata_c33", 128'(wdata32), 128'(words[0]));
            if (c == 64) check("fw_wdata_c64", 128'(wdata32), 128'(words[0]));
            if (c == 65) check("fw_wdata_c65", 128'(wdata32), 128'(words[1]));
            if (c == 97) check("fw_wdata_c97", 128'(wdata32), 128'(words[2]));
            if (c == 39) check("fw_waddr_c39", 128'(waddr32), 128'(32'h40));
            if (c == 40) check("fw_waddr_c40", 128'(waddr32), 128'(32'h41));
            if (c == 72) check("fw_waddr_c72", 128'(waddr32), 128'(32'h42));
            if (c == 103) check("fw_waddr_c103", 128'(waddr32), 128'(32'h42));
        end
        wdata_en = 1'b0;
        check("fw_waddr_end", 128'(waddr32), 128'(32'h43));
        check("fw_ovr",       128'(ovr32),   128'(0));

        // Reset 3 cycles after a latch discards the in-flight write.
        wdata_en = 1'b1;
        shift_bits(32'h77777777, 32, g32, g8);
        tick();
        wdata_en = 1'b0;
        check("rw_wdata", 128'(wdata32), 128'(32'h77777777));
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            check($sformatf("rw_wram%0d", n), 128'(wram32), 128'(0));
        end
        check("rw_waddr", 128'(waddr32),  128'(0));
        check("rw_wdata0", 128'(wdata32), 128'(0));
        check("rw_ch",    ch_out32,       128'(0));
        check("rw_ovr",   128'(ovr32),    128'(0));

        // 8-bit instance: CH_INIT, ident truncation, overrun set and clear.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("d8_ch_init", 128'(ch_out8), 128'(16'hA5A5));
        pulse_capture(EN_IDENT, 4'b0000);
        shift_bits(32'h10, 8, g32, g8);
        check("d8_ident", 128'(g8), 128'(8'hDE));
        pulse_update(EN_WADDR, 4'b0000);
        check("d8_waddr", 128'(waddr8), 128'(8'h10));
        shift_bits(32'h3C, 8, g32, g8);
        pulse_update(EN_NONE, 4'b0010);
        check("d8_ch_upd", 128'(ch_out8), 128'(16'h3CA5));
        shift_bits(32'h33, 8, g32, g8);
        pulse_update(EN_WDATA, 4'b0000);
        check("d8_wdata", 128'(wdata8), 128'(8'h33));
        check("d8_ovr0",  128'(ovr8),   128'(0));
        for (int c = 1; c <= 12; c++) begin
            if (c == 4) begin
                pulse_update(EN_WDATA, 4'b0000);
            end else begin
                tick();
            end
            check($sformatf("d8_wram_c%0d", c), 128'(wram8), 128'(c == 5 || c == 9));
            check($sformatf("d8_ovr_c%0d", c),  128'(ovr8),  128'(c >= 4));
            check($sformatf("d8_waddr_c%0d", c), 128'(waddr8),
                  128'(8'h10 + 8'(c >= 7) + 8'(c >= 11)));
        end
        shift_bits(32'h55, 8, g32, g8);
        pulse_update(EN_WADDR, 4'b0000);
        check("d8_waddr_new", 128'(waddr8), 128'(8'h55));
        check("d8_ovr_clr",   128'(ovr8),   128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
